// File: rtl/barrier_sched_ctrl.sv
// ---------------------------------------------------------------------------
// barrier_sched_ctrl
//
// Hardware barrier controller for the warp scheduler. Warps arriving at one
// of NUM_BARRIERS barriers are held in stalled_mask until the programmed
// participant count is reached. All members are then released together with
// a single-cycle release pulse. Protocol misuse raises a sticky proto_err. A
// barrier that waits too long in COLLECT raises a sticky timeout_err.
//
// Ports
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset. Deassertion is assumed
//                    to be synchronised to clk upstream.
//   bar_req_valid    warp arrival request
//   bar_req_ready    arrival accepted when valid & ready. This signal is low
//                    only while the addressed barrier is releasing.
//   bar_req_wid      arriving warp id
//   bar_req_id       target barrier id
//   bar_req_size_m1  participating warps minus one
//   active_warps     currently active warps
//   stalled_mask     warps held at any barrier (registered)
//   release_valid    one-cycle release pulse
//   release_id       barrier being released
//   release_mask     warps released by that barrier
//   bar_busy         barrier b is collecting arrivals
//   proto_err        sticky protocol-violation flag
//   timeout_err      sticky watchdog flag
//   timeout_id       first barrier that timed out (lowest id on a tie)
// ---------------------------------------------------------------------------
module barrier_sched_ctrl #(
  parameter int NUM_WARPS      = 4,
  parameter int NUM_BARRIERS   = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int NW_WIDTH      = $clog2(NUM_WARPS),
  localparam int NB_WIDTH      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    bar_req_valid,
  output logic                    bar_req_ready,
  input  logic [NW_WIDTH-1:0]     bar_req_wid,
  input  logic [NB_WIDTH-1:0]     bar_req_id,
  input  logic [NW_WIDTH-1:0]     bar_req_size_m1,
  input  logic [NUM_WARPS-1:0]    active_warps,
  output logic [NUM_WARPS-1:0]    stalled_mask,
  output logic                    release_valid,
  output logic [NB_WIDTH-1:0]     release_id,
  output logic [NUM_WARPS-1:0]    release_mask,
  output logic [NUM_BARRIERS-1:0] bar_busy,
  output logic                    proto_err,
  output logic                    timeout_err,
  output logic [NB_WIDTH-1:0]     timeout_id
);

  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
  // The barrier id may address more slots than exist when NUM_BARRIERS is not
  // a full power-of-two span (NUM_BARRIERS = 1). Those slots are never busy.
  localparam int NB_SPAN  = 1 << NB_WIDTH;
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WD_WIDTH-1:0] WD_LAST  = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RELEASE = 2'd2
  } bar_state_e;

  logic [NUM_WARPS-1:0] stalled_reg, stalled_next;
  logic                 release_valid_reg, release_valid_next;
  logic [NB_WIDTH-1:0]  release_id_reg, release_id_next;
  logic [NUM_WARPS-1:0] release_mask_reg, release_mask_next;
  logic                 proto_err_reg, proto_err_next;
  logic                 timeout_err_reg, timeout_err_next;
  logic [NB_WIDTH-1:0]  timeout_id_reg, timeout_id_next;

  logic [NUM_BARRIERS-1:0] in_release;
  logic [NUM_BARRIERS-1:0] in_collect;
  logic [NUM_BARRIERS-1:0] hit_vec;
  logic [NUM_BARRIERS-1:0] complete_vec;
  logic [NUM_BARRIERS-1:0] mismatch_vec;
  logic [NUM_BARRIERS-1:0] expire_vec;
  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] member_vec;
  logic [NB_SPAN-1:0]      in_release_span;
  logic [NUM_WARPS-1:0]    wid_onehot;
  logic                    req_fire;
  logic                    req_reject;
  logic                    req_counted;

  assign in_release_span = NB_SPAN'(in_release);
  assign bar_req_ready   = ~in_release_span[bar_req_id];
  assign req_fire        = bar_req_valid & bar_req_ready;
  // An arrival from an inactive warp, or from a warp that is already held
  // somewhere, is consumed but changes no barrier state.
  assign req_reject      = ~active_warps[bar_req_wid] | stalled_reg[bar_req_wid];
  assign req_counted     = req_fire & ~req_reject;
  assign wid_onehot      = NUM_WARPS'(1) << bar_req_wid;

  // -------------------------------------------------------------------------
  // Per-barrier collection FSM
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_BARRIERS; gi++) begin : g_bar
    bar_state_e           state_reg, state_next;
    logic [NW_WIDTH-1:0]  ctr_reg, ctr_next;
    logic [NW_WIDTH-1:0]  size_reg, size_next;
    logic [NUM_WARPS-1:0] member_reg, member_next;
    logic [WD_WIDTH-1:0]  wdog_reg, wdog_next;
    logic                 hit;
    logic                 complete;
    logic                 mismatch;
    logic                 expire;

    assign hit = req_counted && (bar_req_id == NB_WIDTH'(gi));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_reg  <= ST_IDLE;
        ctr_reg    <= '0;
        size_reg   <= '0;
        member_reg <= '0;
        wdog_reg   <= '0;
      end else begin
        state_reg  <= state_next;
        ctr_reg    <= ctr_next;
        size_reg   <= size_next;
        member_reg <= member_next;
        wdog_reg   <= wdog_next;
      end
    end

    always_comb begin
      state_next  = state_reg;
      ctr_next    = ctr_reg;
      size_next   = size_reg;
      member_next = member_reg;
      wdog_next   = wdog_reg;
      complete    = 1'b0;
      mismatch    = 1'b0;
      expire      = 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (hit) begin
            if (bar_req_size_m1 == '0) begin
              // A single-participant barrier completes on its first arrival.
              complete   = 1'b1;
              state_next = ST_RELEASE;
            end else begin
              state_next  = ST_COLLECT;
              ctr_next    = NW_WIDTH'(1);
              size_next   = bar_req_size_m1;
              member_next = wid_onehot;
              wdog_next   = '0;
            end
          end
        end
        ST_COLLECT: begin
          if (hit) begin
            // Completion uses the size latched on the first arrival, even
            // when this arrival's size disagrees.
            mismatch  = (bar_req_size_m1 != size_reg);
            wdog_next = '0;
            if (ctr_reg == size_reg) begin
              complete    = 1'b1;
              state_next  = ST_RELEASE;
              ctr_next    = '0;
              size_next   = '0;
              member_next = '0;
            end else begin
              ctr_next    = ctr_reg + NW_WIDTH'(1);
              member_next = member_reg | wid_onehot;
            end
          end else if (wdog_reg != WD_LIMIT) begin
            // The counter saturates at the limit. The expiry therefore fires
            // exactly once, and the barrier keeps waiting.
            wdog_next = wdog_reg + WD_WIDTH'(1);
            expire    = (wdog_reg == WD_LAST);
          end
        end
        ST_RELEASE: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    assign in_release[gi]   = (state_reg == ST_RELEASE);
    assign in_collect[gi]   = (state_reg == ST_COLLECT);
    assign hit_vec[gi]      = hit;
    assign complete_vec[gi] = complete;
    assign mismatch_vec[gi] = mismatch;
    assign expire_vec[gi]   = expire;
    assign member_vec[gi]   = member_reg;
  end

  // -------------------------------------------------------------------------
  // Shared stall mask, release pulse and error flags
  // -------------------------------------------------------------------------
  always_comb begin
    release_valid_next = |complete_vec;
    release_id_next    = '0;
    release_mask_next  = '0;
    stalled_next       = stalled_reg;
    // At most one barrier completes per cycle, because only one arrival is
    // accepted per cycle.
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (complete_vec[b]) begin
        release_id_next   = NB_WIDTH'(b);
        release_mask_next = member_vec[b] | wid_onehot;
      end
    end
    if (|complete_vec) begin
      stalled_next = stalled_reg & ~release_mask_next;
    end else if (|hit_vec) begin
      stalled_next = stalled_reg | wid_onehot;
    end

    proto_err_next = proto_err_reg
                   | (req_fire & req_reject)
                   | (|mismatch_vec)
                   | (|(stalled_reg & ~active_warps));

    timeout_err_next = timeout_err_reg | (|expire_vec);
    timeout_id_next  = timeout_id_reg;
    if (!timeout_err_reg) begin
      // Scanning downward leaves the lowest expiring id as the result.
      for (int b = NUM_BARRIERS - 1; b >= 0; b--) begin
        if (expire_vec[b]) begin
          timeout_id_next = NB_WIDTH'(b);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stalled_reg       <= '0;
      release_valid_reg <= 1'b0;
      release_id_reg    <= '0;
      release_mask_reg  <= '0;
      proto_err_reg     <= 1'b0;
      timeout_err_reg   <= 1'b0;
      timeout_id_reg    <= '0;
    end else begin
      stalled_reg       <= stalled_next;
      release_valid_reg <= release_valid_next;
      release_id_reg    <= release_id_next;
      release_mask_reg  <= release_mask_next;
      proto_err_reg     <= proto_err_next;
      timeout_err_reg   <= timeout_err_next;
      timeout_id_reg    <= timeout_id_next;
    end
  end

  assign stalled_mask  = stalled_reg;
  assign release_valid = release_valid_reg;
  assign release_id    = release_id_reg;
  assign release_mask  = release_mask_reg;
  assign bar_busy      = in_collect;
  assign proto_err     = proto_err_reg;
  assign timeout_err   = timeout_err_reg;
  assign timeout_id    = timeout_id_reg;

endmodule

// File: tb/tb_barrier_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_barrier_sched_ctrl
//
// Self-checking bench for barrier_sched_ctrl (4 warps, 4 barriers, 16-cycle
// watchdog). The bench has three parts:
//   * a table of single-cycle vectors,
//   * hand-written multi-cycle sequences: back-to-back barriers, a duplicate
//     arrival, the watchdog, and a mid-operation reset,
//   * randomized epochs checked against a behavioural model that tracks
//     member sets and arrival counts per barrier.
// ---------------------------------------------------------------------------
module tb_barrier_sched_ctrl;

  localparam int TB_NW = 4;
  localparam int TB_NB = 4;
  localparam int TB_T  = 16;

  logic             clk;
  logic             reset_n;
  logic             bar_req_valid;
  logic             bar_req_ready;
  logic [1:0]       bar_req_wid;
  logic [1:0]       bar_req_id;
  logic [1:0]       bar_req_size_m1;
  logic [TB_NW-1:0] active_warps;
  logic [TB_NW-1:0] stalled_mask;
  logic             release_valid;
  logic [1:0]       release_id;
  logic [TB_NW-1:0] release_mask;
  logic [TB_NB-1:0] bar_busy;
  logic             proto_err;
  logic             timeout_err;
  logic [1:0]       timeout_id;

  barrier_sched_ctrl #(
    .NUM_WARPS     (TB_NW),
    .NUM_BARRIERS  (TB_NB),
    .TIMEOUT_CYCLES(TB_T)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bar_req_valid  (bar_req_valid),
    .bar_req_ready  (bar_req_ready),
    .bar_req_wid    (bar_req_wid),
    .bar_req_id     (bar_req_id),
    .bar_req_size_m1(bar_req_size_m1),
    .active_warps   (active_warps),
    .stalled_mask   (stalled_mask),
    .release_valid  (release_valid),
    .release_id     (release_id),
    .release_mask   (release_mask),
    .bar_busy       (bar_busy),
    .proto_err      (proto_err),
    .timeout_err    (timeout_err),
    .timeout_id     (timeout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic ready_seen;
  logic ready_exp;

  // ---------------- behavioural model ----------------
  logic [TB_NW-1:0] m_members [TB_NB];
  int               m_count   [TB_NB];
  int               m_target  [TB_NB];
  int               m_wait    [TB_NB];
  int               rel_last;
  logic             m_rel_valid;
  int               m_rel_id;
  logic [TB_NW-1:0] m_rel_mask;
  logic             m_proto;
  logic             m_terr;
  int               m_tid;

  function automatic logic [TB_NW-1:0] model_stalled();
    logic [TB_NW-1:0] s;
    s = '0;
    for (int b = 0; b < TB_NB; b++) s = s | m_members[b];
    return s;
  endfunction

  function automatic logic [TB_NB-1:0] model_busy();
    logic [TB_NB-1:0] r;
    r = '0;
    for (int b = 0; b < TB_NB; b++) r[b] = (m_count[b] > 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < TB_NB; b++) begin
      m_members[b] = '0;
      m_count[b]   = 0;
      m_target[b]  = 0;
      m_wait[b]    = 0;
    end
    rel_last    = -1;
    m_rel_valid = 1'b0;
    m_rel_id    = 0;
    m_rel_mask  = '0;
    m_proto     = 1'b0;
    m_terr      = 1'b0;
    m_tid       = 0;
  endtask

  // Advance the model by one clock, given this cycle's inputs.
  task automatic model_step(input logic v, input int w, input int b, input int s,
                            input logic [TB_NW-1:0] act);
    logic [TB_NW-1:0] pre;
    logic [TB_NB-1:0] hit;
    int               rel_now;
    int               new_to;
    pre     = model_stalled();
    hit     = '0;
    rel_now = -1;
    new_to  = -1;
    if ((pre & ~act) != '0) m_proto = 1'b1;
    if (v && (b != rel_last)) begin
      if (!act[w] || pre[w]) begin
        m_proto = 1'b1;
      end else begin
        if (m_count[b] == 0) m_target[b] = s;
        else if (s != m_target[b]) m_proto = 1'b1;
        m_members[b][w] = 1'b1;
        m_count[b]++;
        hit[b] = 1'b1;
        if (m_count[b] == m_target[b] + 1) begin
          rel_now      = b;
          m_rel_mask   = m_members[b];
          m_members[b] = '0;
          m_count[b]   = 0;
        end
      end
    end
    for (int bb = 0; bb < TB_NB; bb++) begin
      if (hit[bb]) begin
        m_wait[bb] = 0;
      end else if (m_count[bb] > 0 && m_wait[bb] < TB_T) begin
        m_wait[bb]++;
        if (m_wait[bb] == TB_T && new_to < 0) new_to = bb;
      end
    end
    if (new_to >= 0) begin
      if (!m_terr) m_tid = new_to;
      m_terr = 1'b1;
    end
    m_rel_valid = (rel_now >= 0);
    if (rel_now >= 0) m_rel_id = rel_now;
    else              m_rel_mask = '0;
    rel_last = rel_now;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Apply one cycle of inputs at posedge+1, sample ready mid-cycle, and return
  // at the following posedge+1.
  task automatic apply(input logic v, input int w, input int b, input int s,
                       input logic [TB_NW-1:0] act);
    bar_req_valid   = v;
    bar_req_wid     = 2'(w);
    bar_req_id      = 2'(b);
    bar_req_size_m1 = 2'(s);
    active_warps    = act;
    #2;
    ready_seen = bar_req_ready;
    ready_exp  = (b != rel_last);
    model_step(v, w, b, s, act);
    @(posedge clk);
    #1;
    $display("cyc v=%0d w=%0d b=%0d s=%0d act=%b rdy=%0d stall=%b rv=%0d rid=%0d rm=%b busy=%b pe=%0d te=%0d tid=%0d",
             v, w, b, s, act, ready_seen, stalled_mask, release_valid, release_id,
             release_mask, bar_busy, proto_err, timeout_err, timeout_id);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 0, 0, 0, 4'hF);
  endtask

  task automatic do_reset();
    bar_req_valid   = 1'b0;
    bar_req_wid     = '0;
    bar_req_id      = '0;
    bar_req_size_m1 = '0;
    active_warps    = 4'hF;
    reset_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic compare_model();
    check("rnd_ready", ready_seen, ready_exp);
    check("rnd_stalled", stalled_mask, model_stalled());
    check("rnd_busy", bar_busy, model_busy());
    check("rnd_rel_valid", release_valid, m_rel_valid);
    if (m_rel_valid) begin
      check("rnd_rel_id", release_id, m_rel_id);
      check("rnd_rel_mask", release_mask, m_rel_mask);
    end
    check("rnd_proto", proto_err, m_proto);
    check("rnd_terr", timeout_err, m_terr);
    check("rnd_tid", timeout_id, m_tid);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             v;
    int               w;
    int               b;
    int               s;
    logic [TB_NW-1:0] act;
    logic             exp_ready;
    logic [TB_NW-1:0] exp_stalled;
    logic             exp_rv;
    int               exp_rid;
    logic [TB_NW-1:0] exp_rmask;
    logic [TB_NB-1:0] exp_busy;
    logic             exp_proto;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic             v;
    int               w;
    int               b;
    int               s;
    logic [TB_NW-1:0] act;
    logic [TB_NW-1:0] free;
    int               fav [TB_NB];

    //        v    w  b  s  act    rdy   stalled  rv    rid mask     busy     proto
    tbl[0] = '{1'b1, 0, 1, 3, 4'hF, 1'b1, 4'b0001, 1'b0, 0, 4'b0000, 4'b0010, 1'b0};
    tbl[1] = '{1'b1, 1, 1, 3, 4'hF, 1'b1, 4'b0011, 1'b0, 0, 4'b0000, 4'b0010, 1'b0};
    tbl[2] = '{1'b1, 2, 1, 3, 4'hF, 1'b1, 4'b0111, 1'b0, 0, 4'b0000, 4'b0010, 1'b0};
    tbl[3] = '{1'b1, 3, 1, 3, 4'hF, 1'b1, 4'b0000, 1'b1, 1, 4'b1111, 4'b0000, 1'b0};
    tbl[4] = '{1'b0, 0, 1, 0, 4'hF, 1'b0, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, 1'b0};
    tbl[5] = '{1'b1, 2, 0, 0, 4'hF, 1'b1, 4'b0000, 1'b1, 0, 4'b0100, 4'b0000, 1'b0};
    tbl[6] = '{1'b0, 0, 0, 0, 4'hF, 1'b0, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, 1'b0};
    tbl[7] = '{1'b1, 1, 2, 1, 4'b1101, 1'b1, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, 1'b1};

    // Reset state, observed while reset is held.
    bar_req_valid   = 1'b0;
    bar_req_wid     = '0;
    bar_req_id      = '0;
    bar_req_size_m1 = '0;
    active_warps    = 4'hF;
    reset_n         = 1'b0;
    model_reset();
    #3;
    check("rst_ready", bar_req_ready, 1'b1);
    check("rst_stalled", stalled_mask, 4'b0000);
    check("rst_busy", bar_busy, 4'b0000);
    check("rst_rel_valid", release_valid, 1'b0);
    check("rst_proto", proto_err, 1'b0);
    check("rst_terr", timeout_err, 1'b0);
    check("rst_tid", timeout_id, 2'd0);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].v, tbl[i].w, tbl[i].b, tbl[i].s, tbl[i].act);
      check("tbl_ready", ready_seen, tbl[i].exp_ready);
      check("tbl_stalled", stalled_mask, tbl[i].exp_stalled);
      check("tbl_busy", bar_busy, tbl[i].exp_busy);
      check("tbl_rel_valid", release_valid, tbl[i].exp_rv);
      check("tbl_proto", proto_err, tbl[i].exp_proto);
      if (tbl[i].exp_rv) begin
        check("tbl_rel_id", release_id, tbl[i].exp_rid);
        check("tbl_rel_mask", release_mask, tbl[i].exp_rmask);
      end
    end

    // Barrier 0 releases while warp 3 arrives at barrier 2 in the next cycle.
    do_reset();
    apply(1'b1, 0, 0, 1, 4'hF);
    check("b2b_stalled0", stalled_mask, 4'b0001);
    apply(1'b1, 1, 0, 1, 4'hF);
    check("b2b_rel_valid", release_valid, 1'b1);
    check("b2b_rel_id", release_id, 2'd0);
    check("b2b_rel_mask", release_mask, 4'b0011);
    check("b2b_stalled1", stalled_mask, 4'b0000);
    bar_req_valid   = 1'b1;
    bar_req_wid     = 2'd2;
    bar_req_id      = 2'd0;
    bar_req_size_m1 = 2'd1;
    #1;
    check("b2b_ready_bar0", bar_req_ready, 1'b0);
    bar_req_wid = 2'd3;
    bar_req_id  = 2'd2;
    #1;
    check("b2b_ready_bar2", bar_req_ready, 1'b1);
    model_step(1'b1, 3, 2, 1, 4'hF);
    @(posedge clk);
    #1;
    check("b2b_stalled2", stalled_mask, 4'b1000);
    check("b2b_busy", bar_busy, 4'b0100);
    check("b2b_rel_off", release_valid, 1'b0);

    // A duplicate arrival is consumed without counting.
    do_reset();
    apply(1'b1, 1, 3, 2, 4'hF);
    apply(1'b1, 1, 3, 2, 4'hF);
    check("dup_proto", proto_err, 1'b1);
    check("dup_stalled", stalled_mask, 4'b0010);
    check("dup_busy", bar_busy, 4'b1000);
    apply(1'b1, 0, 3, 2, 4'hF);
    check("dup_no_early_rel", release_valid, 1'b0);
    check("dup_stalled2", stalled_mask, 4'b0011);
    apply(1'b1, 2, 3, 2, 4'hF);
    check("dup_rel_valid", release_valid, 1'b1);
    check("dup_rel_id", release_id, 2'd3);
    check("dup_rel_mask", release_mask, 4'b0111);

    // Watchdog: one arrival, then silence.
    do_reset();
    apply(1'b1, 0, 2, 1, 4'hF);
    for (int k = 1; k <= TB_T; k++) begin
      apply(1'b0, 0, 0, 0, 4'hF);
      if (k == TB_T - 1) check("wd_not_yet", timeout_err, 1'b0);
      if (k == TB_T) begin
        check("wd_terr", timeout_err, 1'b1);
        check("wd_tid", timeout_id, 2'd2);
        check("wd_still_busy", bar_busy, 4'b0100);
      end
    end
    idle(3);
    apply(1'b1, 1, 2, 1, 4'hF);
    check("wd_late_rel", release_valid, 1'b1);
    check("wd_late_mask", release_mask, 4'b0011);
    check("wd_late_id", release_id, 2'd2);
    check("wd_sticky", timeout_err, 1'b1);

    // Mid-operation reset drops pending barrier 1 with no release afterwards.
    do_reset();
    apply(1'b1, 3, 0, 0, 4'b0111);
    check("mr_proto_set", proto_err, 1'b1);
    apply(1'b1, 0, 1, 3, 4'hF);
    apply(1'b1, 1, 1, 3, 4'hF);
    apply(1'b1, 2, 1, 3, 4'hF);
    check("mr_stalled", stalled_mask, 4'b0111);
    bar_req_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_async_stalled", stalled_mask, 4'b0000);
    check("mr_async_busy", bar_busy, 4'b0000);
    check("mr_async_proto", proto_err, 1'b0);
    check("mr_async_rv", release_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 0, 1, 0, 4'hF);
      check("mr_no_release", release_valid, 1'b0);
      check("mr_no_stall", stalled_mask, 4'b0000);
    end

    // Randomized epochs. Even epochs avoid protocol errors, so proto_err must
    // stay low in them. Odd epochs inject every kind of misuse.
    for (int e = 0; e < 8; e++) begin
      do_reset();
      for (int bb = 0; bb < TB_NB; bb++) fav[bb] = $urandom_range(0, 3);
      for (int c = 0; c < 250; c++) begin
        v   = ($urandom_range(0, 99) < 30 + e * 8);
        b   = $urandom_range(0, 3);
        s   = fav[b];
        act = 4'hF;
        w   = $urandom_range(0, 3);
        if ((e % 2) == 0) begin
          free = ~model_stalled();
          if (free == '0) v = 1'b0;
          else while (!free[w]) w = (w + 1) % TB_NW;
        end else begin
          if ($urandom_range(0, 15) == 0) s = $urandom_range(0, 3);
          if ($urandom_range(0, 31) == 0) act[$urandom_range(0, 3)] = 1'b0;
        end
        apply(v, w, b, s, act);
        compare_model();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
